// File: rtl/gs_sdram_sched.sv
// Request scheduler for the GS SDRAM controller: buffers ROM-loader writes, captures
// GS read/write/refresh requests and serialises them onto the single-command port.
module gs_sdram_sched #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned WD_LIMIT   = 255
) (
    input  logic        clk_sys,
    input  logic        areset_n,
    input  logic        loader_act,
    input  logic [31:0] loader_a,
    input  logic [7:0]  loader_d,
    input  logic        loader_wr,
    input  logic [20:0] gs_addr,
    input  logic [7:0]  gs_dout,
    input  logic        gs_rd_n,
    input  logic        gs_wr_n,
    input  logic        gs_rfsh_n,
    output logic [7:0]  gs_din,
    output logic [24:0] sdr_a,
    output logic [7:0]  sdr_di,
    output logic        sdr_rd,
    output logic        sdr_wr,
    output logic        sdr_rfsh,
    input  logic        sdr_idle,
    input  logic [7:0]  sdr_do,
    output logic        fifo_ovf,
    output logic        wd_err
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned WD_W  = $clog2(WD_LIMIT + 2);

    typedef struct packed {
        logic [14:0] addr;
        logic [7:0]  data;
    } ld_entry_t;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_TURN, S_BUSY} state_t;
    typedef enum logic [1:0] {C_LD, C_RFSH, C_WR, C_RD} cmd_t;

    state_t          state_q;
    cmd_t            cmd_q;
    logic [24:0]     sdr_a_q;
    logic [7:0]      sdr_di_q;
    logic            sdr_rd_q, sdr_wr_q, sdr_rfsh_q;
    logic [7:0]      gs_din_q;
    logic [WD_W-1:0] wd_cnt_q;
    logic            wd_err_q;
    logic            fifo_ovf_q;

    logic            rd_n_q, wr_n_q, rfsh_n_q;
    logic            rd_pend_q, wr_pend_q, rfsh_pend_q;
    logic [20:0]     rd_addr_q, wr_addr_q;
    logic [7:0]      wr_data_q;

    ld_entry_t       fifo_q [FIFO_DEPTH];
    logic [CNT_W-1:0] wr_ptr_q, rd_ptr_q;

    logic      fall_rd_c, fall_wr_c, fall_rfsh_c;
    logic      done_c, wd_hit_c;
    logic      clr_rd_c, clr_wr_c, clr_rfsh_c;
    logic      ld_wr_c, push_c, pop_c, fifo_empty_c, fifo_full_c;
    ld_entry_t head_c;
    logic      unused_c;

    assign unused_c = ^loader_a[30:15];

    // GS request edges are only honoured while the loader is not running
    assign fall_rd_c   = rd_n_q   & ~gs_rd_n   & ~loader_act;
    assign fall_wr_c   = wr_n_q   & ~gs_wr_n   & ~loader_act;
    assign fall_rfsh_c = rfsh_n_q & ~gs_rfsh_n & ~loader_act;

    assign wd_hit_c   = (wd_cnt_q >= WD_W'(WD_LIMIT));
    assign done_c     = (state_q == S_BUSY) && (sdr_idle || wd_hit_c);
    assign clr_rd_c   = done_c && (cmd_q == C_RD);
    assign clr_wr_c   = done_c && (cmd_q == C_WR);
    assign clr_rfsh_c = done_c && (cmd_q == C_RFSH);

    assign fifo_empty_c = (wr_ptr_q == rd_ptr_q);
    assign fifo_full_c  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                          (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign ld_wr_c      = loader_wr & loader_a[31];
    assign push_c       = ld_wr_c & ~fifo_full_c;
    assign pop_c        = done_c && (cmd_q == C_LD);
    assign head_c       = fifo_q[rd_ptr_q[PTR_W-1:0]];

    // Loader write buffer storage
    always_ff @(posedge clk_sys) begin
        if (push_c) begin
            fifo_q[wr_ptr_q[PTR_W-1:0]] <= ld_entry_t'{addr: loader_a[14:0], data: loader_d};
        end
    end

    // Loader write buffer pointers and overflow flag
    always_ff @(posedge clk_sys or negedge areset_n) begin
        if (!areset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_ovf_q <= 1'b0;
        end else begin
            if (push_c) wr_ptr_q <= wr_ptr_q + CNT_W'(1);
            if (pop_c)  rd_ptr_q <= rd_ptr_q + CNT_W'(1);
            if (ld_wr_c && fifo_full_c) fifo_ovf_q <= 1'b1;
        end
    end

    // GS edge detection, pending flags and request latches
    always_ff @(posedge clk_sys or negedge areset_n) begin
        if (!areset_n) begin
            rd_n_q      <= 1'b1;
            wr_n_q      <= 1'b1;
            rfsh_n_q    <= 1'b1;
            rd_pend_q   <= 1'b0;
            wr_pend_q   <= 1'b0;
            rfsh_pend_q <= 1'b0;
            rd_addr_q   <= '0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            rd_n_q   <= gs_rd_n;
            wr_n_q   <= gs_wr_n;
            rfsh_n_q <= gs_rfsh_n;
            if (loader_act) begin
                rd_pend_q   <= 1'b0;
                wr_pend_q   <= 1'b0;
                rfsh_pend_q <= 1'b0;
            end else begin
                rd_pend_q   <= fall_rd_c   | (rd_pend_q   & ~clr_rd_c);
                wr_pend_q   <= fall_wr_c   | (wr_pend_q   & ~clr_wr_c);
                rfsh_pend_q <= fall_rfsh_c | (rfsh_pend_q & ~clr_rfsh_c);
            end
            if (fall_rd_c) rd_addr_q <= gs_addr;
            if (fall_wr_c) begin
                wr_addr_q <= gs_addr;
                wr_data_q <= gs_dout;
            end
        end
    end

    // Command sequencer: select, strobe, turnaround, wait for completion
    always_ff @(posedge clk_sys or negedge areset_n) begin
        if (!areset_n) begin
            state_q    <= S_IDLE;
            cmd_q      <= C_LD;
            sdr_a_q    <= '0;
            sdr_di_q   <= '0;
            sdr_rd_q   <= 1'b0;
            sdr_wr_q   <= 1'b0;
            sdr_rfsh_q <= 1'b0;
            gs_din_q   <= 8'hFF;
            wd_cnt_q   <= '0;
            wd_err_q   <= 1'b0;
        end else begin
            sdr_rd_q   <= 1'b0;
            sdr_wr_q   <= 1'b0;
            sdr_rfsh_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (sdr_idle) begin
                        if (!fifo_empty_c) begin
                            cmd_q    <= C_LD;
                            sdr_a_q  <= {10'b0, head_c.addr};
                            sdr_di_q <= head_c.data;
                            sdr_wr_q <= 1'b1;
                            state_q  <= S_ISSUE;
                        end else if (rfsh_pend_q && !loader_act) begin
                            cmd_q      <= C_RFSH;
                            sdr_rfsh_q <= 1'b1;
                            state_q    <= S_ISSUE;
                        end else if (wr_pend_q && !loader_act) begin
                            cmd_q    <= C_WR;
                            sdr_a_q  <= {4'b0, wr_addr_q};
                            sdr_di_q <= wr_data_q;
                            sdr_wr_q <= 1'b1;
                            state_q  <= S_ISSUE;
                        end else if (rd_pend_q && !loader_act) begin
                            cmd_q    <= C_RD;
                            sdr_a_q  <= {4'b0, rd_addr_q};
                            sdr_rd_q <= 1'b1;
                            state_q  <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    wd_cnt_q <= '0;
                    state_q  <= S_TURN;
                end
                S_TURN: begin
                    wd_cnt_q <= wd_cnt_q + WD_W'(1);
                    state_q  <= S_BUSY;
                end
                S_BUSY: begin
                    if (sdr_idle) begin
                        if (cmd_q == C_RD) gs_din_q <= sdr_do;
                        state_q <= S_IDLE;
                    end else if (wd_hit_c) begin
                        wd_err_q <= 1'b1;
                        state_q  <= S_IDLE;
                    end else begin
                        wd_cnt_q <= wd_cnt_q + WD_W'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign gs_din   = gs_din_q;
    assign sdr_a    = sdr_a_q;
    assign sdr_di   = sdr_di_q;
    assign sdr_rd   = sdr_rd_q;
    assign sdr_wr   = sdr_wr_q;
    assign sdr_rfsh = sdr_rfsh_q;
    assign fifo_ovf = fifo_ovf_q;
    assign wd_err   = wd_err_q;

endmodule

// File: tb/tb_gs_sdram_sched.sv
// Scoreboard bench for gs_sdram_sched: stimulus queues expected strobes, a monitor
// checks every strobe the DUT presents; a small controller model drives sdr_idle.
module tb_gs_sdram_sched;

    localparam int BUSY_LEN = 5;
    localparam int K_RD = 0, K_WR = 1, K_RFSH = 2;

    typedef struct {
        int          kind;
        logic [24:0] a;
        logic [7:0]  d;
        int          cyc;
    } exp_t;

    logic        clk_sys = 1'b0;
    logic        areset_n;
    logic        loader_act, loader_wr;
    logic [31:0] loader_a;
    logic [7:0]  loader_d;
    logic [20:0] gs_addr;
    logic [7:0]  gs_dout;
    logic        gs_rd_n, gs_wr_n, gs_rfsh_n;
    logic [7:0]  gs_din;
    logic [24:0] sdr_a;
    logic [7:0]  sdr_di;
    logic        sdr_rd, sdr_wr, sdr_rfsh;
    logic        sdr_idle;
    logic [7:0]  sdr_do;
    logic        fifo_ovf, wd_err;

    logic        force_busy;
    int          busy_cnt;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    int          n_strobes = 0;
    int          last_sc = -1;
    int          mon_kind;
    exp_t        mon_e;
    exp_t        exp_q[$];

    gs_sdram_sched dut (
        .clk_sys   (clk_sys),
        .areset_n  (areset_n),
        .loader_act(loader_act),
        .loader_a  (loader_a),
        .loader_d  (loader_d),
        .loader_wr (loader_wr),
        .gs_addr   (gs_addr),
        .gs_dout   (gs_dout),
        .gs_rd_n   (gs_rd_n),
        .gs_wr_n   (gs_wr_n),
        .gs_rfsh_n (gs_rfsh_n),
        .gs_din    (gs_din),
        .sdr_a     (sdr_a),
        .sdr_di    (sdr_di),
        .sdr_rd    (sdr_rd),
        .sdr_wr    (sdr_wr),
        .sdr_rfsh  (sdr_rfsh),
        .sdr_idle  (sdr_idle),
        .sdr_do    (sdr_do),
        .fifo_ovf  (fifo_ovf),
        .wd_err    (wd_err)
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) cyc <= cyc + 1;

    // Controller model: any strobe makes it busy for BUSY_LEN cycles
    always @(posedge clk_sys or negedge areset_n) begin
        if (!areset_n)                    busy_cnt <= 0;
        else if (sdr_rd | sdr_wr | sdr_rfsh) busy_cnt <= BUSY_LEN;
        else if (busy_cnt != 0)           busy_cnt <= busy_cnt - 1;
    end
    assign sdr_idle = !force_busy && (busy_cnt == 0);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input int kind, input logic [24:0] a, input logic [7:0] d, input int c);
        exp_t e;
        e.kind = kind; e.a = a; e.d = d; e.cyc = c;
        exp_q.push_back(e);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk_sys);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk_sys);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL %s_timeout: %0d strobes outstanding, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Monitor: every strobe must match the head of the expected queue
    always @(negedge clk_sys) begin
        if (!areset_n) begin
            last_sc = -1;
        end else if (sdr_rd | sdr_wr | sdr_rfsh) begin
            n_strobes++;
            chk("one_strobe", 32'(sdr_rd) + 32'(sdr_wr) + 32'(sdr_rfsh), 32'd1);
            if (last_sc >= 0) begin
                n_cmp++;
                if (cyc - last_sc < 4) begin
                    n_err++;
                    $display("FAIL strobe_gap: got %0d cycles expected >= 4", cyc - last_sc);
                end
            end
            last_sc = cyc;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_strobe: got rd=%0b wr=%0b rfsh=%0b a=0x%0h expected none (cycle %0d)",
                         sdr_rd, sdr_wr, sdr_rfsh, sdr_a, cyc);
            end else begin
                mon_e    = exp_q.pop_front();
                mon_kind = sdr_rd ? K_RD : (sdr_wr ? K_WR : K_RFSH);
                chk("strobe_kind", 32'(mon_kind), 32'(mon_e.kind));
                if (mon_e.kind != K_RFSH) chk("sdr_a", 32'(sdr_a), 32'(mon_e.a));
                if (mon_e.kind == K_WR)   chk("sdr_di", 32'(sdr_di), 32'(mon_e.d));
                if (mon_e.cyc >= 0)       chk("strobe_cycle", 32'(cyc), 32'(mon_e.cyc));
            end
        end
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_gs_din"},   32'(gs_din),   32'hFF);
        chk({tag, "_sdr_a"},    32'(sdr_a),    32'h0);
        chk({tag, "_sdr_di"},   32'(sdr_di),   32'h0);
        chk({tag, "_strobes"},  32'({sdr_rd, sdr_wr, sdr_rfsh}), 32'h0);
        chk({tag, "_fifo_ovf"}, 32'(fifo_ovf), 32'h0);
        chk({tag, "_wd_err"},   32'(wd_err),   32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int s0;
        areset_n = 1'b0; force_busy = 1'b0;
        loader_act = 1'b0; loader_wr = 1'b0; loader_a = '0; loader_d = '0;
        gs_addr = '0; gs_dout = '0; gs_rd_n = 1'b1; gs_wr_n = 1'b1; gs_rfsh_n = 1'b1;
        sdr_do = 8'h00;
        repeat (3) @(negedge clk_sys);
        chk_reset_vals("rst");
        areset_n = 1'b1;
        repeat (2) @(negedge clk_sys);

        // GS read with exact latency and read-data timing
        n = cyc;
        gs_addr = 21'h012345; gs_rd_n = 1'b0; sdr_do = 8'hA5;
        push_exp(K_RD, 25'h0012345, 8'h00, n + 2);
        wait_cyc(n + 8);
        chk("rd_gs_din_before", 32'(gs_din), 32'hFF);
        wait_cyc(n + 9);
        chk("rd_gs_din_after", 32'(gs_din), 32'hA5);
        drain("rd");
        gs_rd_n = 1'b1;
        repeat (2) @(negedge clk_sys);

        // Loader burst into a stalled controller: 4 buffered, 2 dropped
        force_busy = 1'b1; loader_act = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_sys);
            if (i == 4) chk("ovf_after_4", 32'(fifo_ovf), 32'h0);
            loader_wr = 1'b1;
            loader_a  = 32'h8000_0000 + 32'(i);
            loader_d  = 8'h10 + 8'(i);
            if (i < 4) push_exp(K_WR, 25'(i), 8'h10 + 8'(i), -1);
        end
        @(negedge clk_sys);
        loader_wr = 1'b0;
        chk("ovf_after_6", 32'(fifo_ovf), 32'h1);
        force_busy = 1'b0; loader_act = 1'b0;
        drain("burst");
        repeat (5) @(negedge clk_sys);

        // Contention: FIFO entry, then rfsh/wr/rd edges in one cycle
        force_busy = 1'b1;
        loader_wr = 1'b1; loader_a = 32'h8000_1234; loader_d = 8'h5A;
        push_exp(K_WR, 25'h0001234, 8'h5A, -1);
        @(negedge clk_sys);
        loader_wr = 1'b0;
        gs_addr = 21'h01ABCD; gs_dout = 8'h3C; sdr_do = 8'h77;
        gs_rd_n = 1'b0; gs_wr_n = 1'b0; gs_rfsh_n = 1'b0;
        push_exp(K_RFSH, 25'h0, 8'h00, -1);
        push_exp(K_WR, 25'h001ABCD, 8'h3C, -1);
        push_exp(K_RD, 25'h001ABCD, 8'h00, -1);
        @(negedge clk_sys);
        force_busy = 1'b0;
        drain("contention");
        repeat (10) @(negedge clk_sys);
        chk("contention_gs_din", 32'(gs_din), 32'h77);
        gs_rd_n = 1'b1; gs_wr_n = 1'b1; gs_rfsh_n = 1'b1;
        repeat (2) @(negedge clk_sys);

        // loader_act clears an existing read pend and ignores a refresh edge
        s0 = n_strobes;
        force_busy = 1'b1;
        gs_addr = 21'h000123; gs_rd_n = 1'b0;
        repeat (2) @(negedge clk_sys);
        loader_act = 1'b1;
        @(negedge clk_sys);
        gs_rfsh_n = 1'b0;
        repeat (3) @(negedge clk_sys);
        loader_act = 1'b0; force_busy = 1'b0;
        repeat (20) @(negedge clk_sys);
        chk("loader_act_no_strobe", 32'(n_strobes), 32'(s0));
        gs_rd_n = 1'b1; gs_rfsh_n = 1'b1;
        repeat (10) @(negedge clk_sys);
        chk("loader_act_no_strobe_late", 32'(n_strobes), 32'(s0));

        // Asynchronous reset in the middle of a read's BUSY phase
        n = cyc;
        gs_addr = 21'h0ABCDE; gs_rd_n = 1'b0; sdr_do = 8'h99;
        push_exp(K_RD, 25'h00ABCDE, 8'h00, n + 2);
        wait_cyc(n + 5);
        chk("pre_reset_sdr_a", 32'(sdr_a), 32'h00ABCDE);
        areset_n = 1'b0; gs_rd_n = 1'b1;
        #1;
        chk_reset_vals("async");
        drain("async");
        repeat (2) @(negedge clk_sys);
        areset_n = 1'b1;
        repeat (2) @(negedge clk_sys);

        // Watchdog: read never completes, then a fresh read is served
        n = cyc;
        gs_addr = 21'h000777; gs_rd_n = 1'b0; sdr_do = 8'h11;
        push_exp(K_RD, 25'h0000777, 8'h00, n + 2);
        wait_cyc(n + 2);
        force_busy = 1'b1;
        wait_cyc(n + 258);
        chk("wd_err_before", 32'(wd_err), 32'h0);
        wait_cyc(n + 259);
        chk("wd_err_after", 32'(wd_err), 32'h1);
        chk("wd_gs_din", 32'(gs_din), 32'hFF);
        drain("wd");
        force_busy = 1'b0; gs_rd_n = 1'b1;
        repeat (2) @(negedge clk_sys);
        n = cyc;
        gs_addr = 21'h000888; gs_rd_n = 1'b0; sdr_do = 8'h5C;
        push_exp(K_RD, 25'h0000888, 8'h00, n + 2);
        wait_cyc(n + 8);
        chk("post_wd_gs_din_before", 32'(gs_din), 32'hFF);
        wait_cyc(n + 9);
        chk("post_wd_gs_din_after", 32'(gs_din), 32'h5C);
        chk("wd_err_sticky", 32'(wd_err), 32'h1);
        drain("post_wd");
        gs_rd_n = 1'b1;
        repeat (5) @(negedge clk_sys);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
